uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK and RST.
REQ-002 Port list (name, direction, width, meaning):
- CLK  in  1  system clock, Prescale x bit rate
- RST  in  1  synchronous active-high reset
- S_DATA  in  1  serial line, idle high
- sampled_bit  in  1  majority bit from the data sampling stage
- Prescale  in  6  clocks per bit
- PAR_EN  in  1  parity bit present
- PAR_TYP  in  1  0 even, 1 odd
- edge_count  out  6  clock index within the current bit, fed to data sampling
- samp_en  out  1  Enable to data sampling
- P_DATA  out  8  received byte
- data_valid  out  1  one-cycle pulse, P_DATA good
- parity_error  out  1  one-cycle pulse
- stop_error  out  1  one-cycle pulse

Function
REQ-003 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-004 In IDLE, S_DATA==0 SHALL move the FSM to START on the next cycle, with edge_count=0 and bit_count=0.
REQ-005 At that same transition, Prescale, PAR_EN and PAR_TYP SHALL be latched; changes during a frame SHALL be ignored.
REQ-006 A latched Prescale below 8 SHALL be treated as 8; an odd Prescale SHALL be rounded down to the even value.
REQ-007 In every state except IDLE, edge_count SHALL count 0..Prescale-1 and then wrap to 0; each wrap SHALL end one bit period.
REQ-008 In IDLE, edge_count SHALL be held at 0.
REQ-009 samp_en SHALL be 1 in every state except IDLE; in IDLE it SHALL be 0.
REQ-010 sampled_bit SHALL be consumed only in the cycle where edge_count==Prescale-1 (the "bit end").
REQ-011 START, at bit end: sampled_bit==0 -> DATA; sampled_bit==1 -> IDLE (glitch rejection), with no outputs pulsed.
REQ-012 DATA: at each bit end, sampled_bit SHALL be shifted into an internal 8-bit register, LSB first, and bit_count incremented.
REQ-013 DATA: after the 8th bit end, the FSM SHALL go to PARITY if latched PAR_EN==1, else to STOP.
REQ-014 PARITY: at bit end, the expected bit SHALL be the XOR of the 8 data bits (even), inverted when PAR_TYP==1 (odd).
REQ-015 PARITY: a mismatch SHALL set an internal par_err flag; the FSM SHALL then go to STOP.
REQ-016 STOP, at bit end, the FSM SHALL always return to IDLE, with exactly one outcome:
- sampled_bit==0 -> stop_error pulse for one cycle
- else if par_err -> parity_error pulse for one cycle
- else -> P_DATA loaded from the shift register, data_valid pulse for one cycle
REQ-017 P_DATA SHALL change only on a data_valid cycle and otherwise hold its last value.
REQ-018 At most one of data_valid, parity_error and stop_error SHALL be high in any cycle.
REQ-019 Back-to-back frames: S_DATA==0 in the first IDLE cycle after STOP SHALL start a new frame with no lost cycle beyond that one.
REQ-020 A low S_DATA level seen in IDLE (not an edge) SHALL count as a start; a line held low after a stop_error SHALL therefore re-enter START.
REQ-021 The maximum frame is 11 bits x Prescale cycles; no counter SHALL overflow with Prescale <= 32.

Reset
REQ-022 While RST==1 at a CLK edge, the FSM SHALL enter IDLE.
REQ-023 While RST==1, edge_count, bit_count, the shift register, par_err, P_DATA, samp_en, data_valid, parity_error and stop_error SHALL all be 0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no output pulse; reception SHALL resume from IDLE on the cycle after RST deasserts.

Structure
REQ-025 A shared package uart_rx_pkg SHALL hold the state enum, DATA_WIDTH=8, PRESCALE_MIN=8 and the edge_count width (6).
REQ-026 The edge/bit counter SHALL be a sub-module uart_rx_edge_bit_counter, with inputs enable and prescale and outputs edge_count, bit_end and bit_count.
REQ-027 The FSM, shift register, parity check and stop check SHALL reside in uart_rx_ctrl.

Verification
REQ-028 A bench SHALL cover these directed scenarios:
- Prescale=8, PAR_EN=0, byte 0xA5 framed -> data_valid one cycle, P_DATA=0xA5, 80 cycles after the start detect.
- Prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x3C, parity bit 0 -> data_valid, P_DATA=0x3C; same byte with parity bit 1 -> parity_error pulse, P_DATA unchanged.
- Prescale=32, PAR_TYP=1, byte 0x01, stop bit 0 -> stop_error pulse only; FSM back in IDLE.
- S_DATA low for 2 cycles then high, Prescale=8 -> START then IDLE after 8 cycles; no pulses; samp_en low again.
- Two back-to-back frames 0x55 then 0xFF, Prescale=8, no idle gap -> two data_valid pulses, P_DATA 0x55 then 0xFF.
- RST=1 at bit 4 of DATA -> all outputs 0 next cycle; the following clean frame 0x81 -> data_valid, P_DATA=0x81.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// Holds the FSM state encoding and the prescale normalisation helper.
package uart_rx_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int PRESCALE_MIN = 8;
  localparam int EDGE_W       = 6;
  localparam int BIT_W        = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Short prescales leave no room for a mid-bit sample; odd ones
  // have no clean centre, so both are normalised.
  function automatic logic [EDGE_W-1:0] norm_prescale(
    input logic [EDGE_W-1:0] p
  );
    if (p < EDGE_W'(PRESCALE_MIN))
      return EDGE_W'(PRESCALE_MIN);
    return {p[EDGE_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Edge and bit counter for the UART receiver.
// Counts clocks within a bit and completed bits while enabled.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [EDGE_W-1:0] prescale,
  output logic [EDGE_W-1:0] edge_count,
  output logic              bit_end,
  output logic [BIT_W-1:0]  bit_count
);

  assign bit_end = enable &&
    (edge_count == prescale - EDGE_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (!enable) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (bit_end) begin
      edge_count <= '0;
      bit_count  <= bit_count + BIT_W'(1);
    end else begin
      edge_count <= edge_count + EDGE_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, shift register,
// parity and stop checks around the edge/bit counter.
module uart_rx_ctrl
  import uart_rx_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  S_DATA,
  input  logic                  sampled_bit,
  input  logic [EDGE_W-1:0]     Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [EDGE_W-1:0]     edge_count,
  output logic                  samp_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  state_t state, state_nxt;

  logic [EDGE_W-1:0]     ps_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_err;
  logic                  bit_end;
  logic [BIT_W-1:0]      bit_count;
  logic                  start_det;
  logic                  last_data;
  logic                  par_exp;
  logic                  dv_nxt;
  logic                  pe_nxt;
  logic                  se_nxt;

  assign samp_en   = (state != IDLE);
  assign start_det = (state == IDLE) && !S_DATA;
  // bit_count includes the start bit, so the 8th data bit ends at 8
  assign last_data = (bit_count == BIT_W'(DATA_WIDTH));
  assign par_exp   = (^shreg) ^ par_typ_q;

  uart_rx_edge_bit_counter u_cnt (
    .clk        (CLK),
    .rst        (RST),
    .enable     (samp_en),
    .prescale   (ps_q),
    .edge_count (edge_count),
    .bit_end    (bit_end),
    .bit_count  (bit_count)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dv_nxt    = 1'b0;
    pe_nxt    = 1'b0;
    se_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!S_DATA) state_nxt = START;
      end
      START: begin
        if (bit_end)
          state_nxt = sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end && last_data)
          state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          if (!sampled_bit) se_nxt = 1'b1;
          else if (par_err) pe_nxt = 1'b1;
          else              dv_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ps_q         <= EDGE_W'(PRESCALE_MIN);
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      shreg        <= '0;
      par_err      <= 1'b0;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      if (start_det) begin
        ps_q      <= norm_prescale(Prescale);
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        par_err   <= 1'b0;
      end
      if (state == DATA && bit_end)
        shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
      if (state == PARITY && bit_end &&
          sampled_bit != par_exp)
        par_err <= 1'b1;
      if (dv_nxt) P_DATA <= shreg;
      data_valid   <= dv_nxt;
      parity_error <= pe_nxt;
      stop_error   <= se_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl with a mid-bit
// sampling model standing in for the data sampling stage.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       S_DATA = 1'b1;
  logic       sampled_bit = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] edge_count;
  logic       samp_en;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         lat;
    int         t0;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [5:0] tb_half = 6'd4;
  logic [7:0] last_good = 8'h00;

  uart_rx_ctrl dut (
    .CLK          (CLK),
    .RST          (RST),
    .S_DATA       (S_DATA),
    .sampled_bit  (sampled_bit),
    .Prescale     (Prescale),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .edge_count   (edge_count),
    .samp_en      (samp_en),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .stop_error   (stop_error)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK)
    if (edge_count == tb_half) sampled_bit <= S_DATA;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic int norm(input logic [5:0] p);
    if (p < 6'd8) return 8;
    return int'({p[5:1], 1'b0});
  endfunction

  always @(negedge CLK) begin
    if (!RST && (data_valid || parity_error || stop_error)) begin
      check("onehot",
            32'($countones({data_valid, parity_error, stop_error})), 1);
      if (q.size() == 0) begin
        check("unexpected",
              32'({data_valid, parity_error, stop_error}), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("kind",
              32'({data_valid, parity_error, stop_error}),
              32'(e.kind));
        check("pdata", 32'(P_DATA), 32'(e.data));
        if (e.lat != 0)
          check("latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end

  task automatic send(input logic [7:0] d,
                      input logic [5:0] ps,
                      input logic en,
                      input logic typ,
                      input logic pflip,
                      input logic stopv,
                      input bit   chk_lat,
                      input int   abort_cyc);
    int         p;
    int         n;
    int         cnt;
    logic [10:0] bits;
    exp_t       e;
    p = norm(ps);
    n = en ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (en) bits[9] = (^d) ^ typ ^ pflip;
    bits[n-1] = stopv;
    @(negedge CLK);
    Prescale = ps;
    PAR_EN = en;
    PAR_TYP = typ;
    tb_half = 6'(p / 2);
    if (abort_cyc == 0) begin
      if (!stopv) begin
        e.kind = 3'b001;
        e.data = last_good;
      end else if (en && pflip) begin
        e.kind = 3'b010;
        e.data = last_good;
      end else begin
        e.kind = 3'b100;
        e.data = d;
        last_good = d;
      end
      e.lat = chk_lat ? n * p : 0;
      e.t0 = cyc + 1;
      q.push_back(e);
    end
    cnt = 0;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < p; c++) begin
        if (!(b == 0 && c == 0)) @(negedge CLK);
        S_DATA = bits[b];
        if (b == 1 && c == 0) begin
          Prescale = 6'd63 - ps;
          PAR_EN = ~en;
          PAR_TYP = ~typ;
        end
        cnt++;
        if (abort_cyc != 0 && cnt == abort_cyc) return;
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge CLK);
      S_DATA = 1'b1;
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_edge", 32'(edge_count), 0);
    check("rst_samp", 32'(samp_en), 0);
    check("rst_pdata", 32'(P_DATA), 0);
    check("rst_pulse",
          32'({data_valid, parity_error, stop_error}), 0);
    RST = 1'b0;
    idle(4);

    send(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    idle(6);

    send(8'h3C, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    idle(6);
    send(8'h3C, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    idle(6);

    send(8'h01, 6'd32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(6);
    check("stop_idle_samp", 32'(samp_en), 0);
    check("stop_idle_edge", 32'(edge_count), 0);

    @(negedge CLK) S_DATA = 1'b0;
    Prescale = 6'd8;
    tb_half = 6'd4;
    @(negedge CLK) S_DATA = 1'b0;
    @(negedge CLK) S_DATA = 1'b1;
    check("glitch_start", 32'(samp_en), 1);
    repeat (6) @(negedge CLK);
    check("glitch_hold", 32'(samp_en), 1);
    @(negedge CLK);
    check("glitch_idle", 32'(samp_en), 0);
    check("glitch_edge", 32'(edge_count), 0);
    idle(4);

    send(8'h55, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    send(8'hFF, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle(6);

    send(8'h5A, 6'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    idle(4);
    send(8'hC3, 6'd17, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    idle(4);

    send(8'hE7, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5 * 8 + 2);
    @(negedge CLK);
    RST = 1'b1;
    S_DATA = 1'b1;
    @(negedge CLK);
    check("mid_rst_edge", 32'(edge_count), 0);
    check("mid_rst_samp", 32'(samp_en), 0);
    check("mid_rst_pdata", 32'(P_DATA), 0);
    check("mid_rst_pulse",
          32'({data_valid, parity_error, stop_error}), 0);
    RST = 1'b0;
    last_good = 8'h00;
    idle(3);
    send(8'h81, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    idle(10);

    check("drain", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
